// File: rtl/instruction_decode_if.sv
// ID-stage bus: fetch instruction and WB write port in, ID/EX pipeline register out.
interface instruction_decode_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) ();
  localparam int AW = $clog2(NREG);

  logic [7:0]        instruction_code;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              idex_valid;
  logic [1:0]        idex_op;
  logic              idex_reg_write;
  logic [AW-1:0]     idex_rd;
  logic [AW-1:0]     idex_rs;
  logic [DATA_W-1:0] idex_rd_data;
  logic [DATA_W-1:0] idex_rs_data;

  modport master (
    output instruction_code, wb_en, wb_addr, wb_data,
    input  idex_valid, idex_op, idex_reg_write, idex_rd, idex_rs,
           idex_rd_data, idex_rs_data
  );

  modport slave (
    input  instruction_code, wb_en, wb_addr, wb_data,
    output idex_valid, idex_op, idex_reg_write, idex_rd, idex_rs,
           idex_rd_data, idex_rs_data
  );
endinterface

// File: rtl/instruction_decode.sv
// ID stage: IF/ID register, decode, 8x8 register file with WB write and WB-to-ID bypass,
// and the ID/EX pipeline register.
module instruction_decode #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input logic               clk,
  input logic               reset,
  instruction_decode_if.slave bus
);
  localparam int AW = $clog2(NREG);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;

  logic [7:0]        ir_q;
  logic              ifid_valid_q;
  logic [DATA_W-1:0] rf_q [NREG];

  logic              idex_valid_q;
  logic [1:0]        idex_op_q,        idex_op_d;
  logic              idex_reg_write_q, idex_reg_write_d;
  logic [AW-1:0]     idex_rd_q,        idex_rd_d;
  logic [AW-1:0]     idex_rs_q,        idex_rs_d;
  logic [DATA_W-1:0] idex_rd_data_q,   idex_rd_data_d;
  logic [DATA_W-1:0] idex_rs_data_q,   idex_rs_data_d;

  logic [AW-1:0]     rd_idx, rs_idx;
  logic [DATA_W-1:0] rd_rdata, rs_rdata;

  always_comb begin
    rd_idx = ir_q[5:3];
    rs_idx = ir_q[2:0];
    // A WB write landing this cycle is visible to ID reads before it reaches the array
    rd_rdata = (bus.wb_en && (bus.wb_addr == rd_idx)) ? bus.wb_data : rf_q[rd_idx];
    rs_rdata = (bus.wb_en && (bus.wb_addr == rs_idx)) ? bus.wb_data : rf_q[rs_idx];

    idex_op_d        = OP_MOV;
    idex_reg_write_d = 1'b0;
    idex_rd_d        = '0;
    idex_rs_d        = '0;
    idex_rd_data_d   = '0;
    idex_rs_data_d   = '0;
    if (ir_q[7]) begin
      idex_op_d = OP_JMP;
    end else begin
      idex_op_d        = ir_q[6] ? OP_ADD : OP_MOV;
      idex_reg_write_d = 1'b1;
      idex_rd_d        = rd_idx;
      idex_rs_d        = rs_idx;
      idex_rd_data_d   = rd_rdata;
      idex_rs_data_d   = rs_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q             <= '0;
      ifid_valid_q     <= 1'b0;
      idex_valid_q     <= 1'b0;
      idex_op_q        <= '0;
      idex_reg_write_q <= 1'b0;
      idex_rd_q        <= '0;
      idex_rs_q        <= '0;
      idex_rd_data_q   <= '0;
      idex_rs_data_q   <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= DATA_W'(i);
      end
    end else begin
      ir_q             <= bus.instruction_code;
      ifid_valid_q     <= 1'b1;
      idex_valid_q     <= ifid_valid_q;
      idex_op_q        <= idex_op_d;
      idex_reg_write_q <= idex_reg_write_d;
      idex_rd_q        <= idex_rd_d;
      idex_rs_q        <= idex_rs_d;
      idex_rd_data_q   <= idex_rd_data_d;
      idex_rs_data_q   <= idex_rs_data_d;
      if (bus.wb_en) begin
        rf_q[bus.wb_addr] <= bus.wb_data;
      end
    end
  end

  assign bus.idex_valid     = idex_valid_q;
  assign bus.idex_op        = idex_op_q;
  assign bus.idex_reg_write = idex_reg_write_q;
  assign bus.idex_rd        = idex_rd_q;
  assign bus.idex_rs        = idex_rs_q;
  assign bus.idex_rd_data   = idex_rd_data_q;
  assign bus.idex_rs_data   = idex_rs_data_q;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode, latency, bypass, write-back and async reset.
module tb_instruction_decode;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  instruction_decode_if #(.DATA_W(8), .NREG(8)) bus ();

  instruction_decode #(.DATA_W(8), .NREG(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, op, reg_write, rd, rs, rd_data, rs_data}
  logic [25:0] obs;
  assign obs = {bus.idex_valid, bus.idex_op, bus.idex_reg_write, bus.idex_rd,
                bus.idex_rs, bus.idex_rd_data, bus.idex_rs_data};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.instruction_code = 8'h00;
    bus.wb_en   = 1'b0;
    bus.wb_addr = 3'd0;
    bus.wb_data = 8'h00;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    tests++;
    if (obs !== 26'h0) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", obs, 26'h0);
    end
    #8 reset = 1'b1;   // released at t=12, away from the posedge at t=15
    step();
    tests++;
    if (bus.idex_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_edge_valid: got %b want 0", bus.idex_valid);
    end
    step();
    tests++;
    if (obs !== {1'b1, 2'b00, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL second_edge_mov00: got %h want %h", obs,
               {1'b1, 2'b00, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00});
    end
  endtask

  task automatic test_add();
    bus.instruction_code = 8'h4B;
    step();
    step();
    tests++;
    if (obs !== {1'b1, 2'b01, 1'b1, 3'd1, 3'd3, 8'h01, 8'h03}) begin
      fails++;
      $display("FAIL add_r1_r3: got %h want %h", obs,
               {1'b1, 2'b01, 1'b1, 3'd1, 3'd3, 8'h01, 8'h03});
    end
  endtask

  task automatic test_jmp();
    bus.instruction_code = 8'h85;
    step();
    step();
    tests++;
    if (obs !== {1'b1, 2'b10, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL jmp_85: got %h want %h", obs,
               {1'b1, 2'b10, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00});
    end
  endtask

  task automatic test_bypass();
    bus.instruction_code = 8'h1A;
    step();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd2;
    bus.wb_data = 8'hA5;
    step();
    bus.wb_en = 1'b0;
    tests++;
    if (obs !== {1'b1, 2'b00, 1'b1, 3'd3, 3'd2, 8'h03, 8'hA5}) begin
      fails++;
      $display("FAIL bypass_rs: got %h want %h", obs,
               {1'b1, 2'b00, 1'b1, 3'd3, 3'd2, 8'h03, 8'hA5});
    end
    step();
    tests++;
    if (bus.idex_rs_data !== 8'hA5) begin
      fails++;
      $display("FAIL r2_after_bypass: got %h want a5", bus.idex_rs_data);
    end
  endtask

  task automatic test_bypass_same_reg();
    bus.instruction_code = 8'h24;
    step();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd4;
    bus.wb_data = 8'h5A;
    step();
    bus.wb_en = 1'b0;
    tests++;
    if (obs !== {1'b1, 2'b00, 1'b1, 3'd4, 3'd4, 8'h5A, 8'h5A}) begin
      fails++;
      $display("FAIL bypass_rd_eq_rs: got %h want %h", obs,
               {1'b1, 2'b00, 1'b1, 3'd4, 3'd4, 8'h5A, 8'h5A});
    end
  endtask

  task automatic test_write_readback();
    bus.instruction_code = 8'h00;
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd7;
    bus.wb_data = 8'h3C;
    step();
    bus.wb_en = 1'b0;
    bus.instruction_code = 8'h3F;
    step();
    step();
    tests++;
    if (obs !== {1'b1, 2'b00, 1'b1, 3'd7, 3'd7, 8'h3C, 8'h3C}) begin
      fails++;
      $display("FAIL write_readback_r7: got %h want %h", obs,
               {1'b1, 2'b00, 1'b1, 3'd7, 3'd7, 8'h3C, 8'h3C});
    end
  endtask

  task automatic test_back_to_back();
    // R1=1, R2=A5, R3=3, R5=5 at this point
    bus.instruction_code = 8'h4A;
    step();
    bus.instruction_code = 8'h80;
    step();
    tests++;
    if (obs !== {1'b1, 2'b01, 1'b1, 3'd1, 3'd2, 8'h01, 8'hA5}) begin
      fails++;
      $display("FAIL b2b_add_r1_r2: got %h want %h", obs,
               {1'b1, 2'b01, 1'b1, 3'd1, 3'd2, 8'h01, 8'hA5});
    end
    bus.instruction_code = 8'h1D;
    step();
    tests++;
    if (obs !== {1'b1, 2'b10, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL b2b_jmp: got %h want %h", obs,
               {1'b1, 2'b10, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00});
    end
    step();
    tests++;
    if (obs !== {1'b1, 2'b00, 1'b1, 3'd3, 3'd5, 8'h03, 8'h05}) begin
      fails++;
      $display("FAIL b2b_mov_r3_r5: got %h want %h", obs,
               {1'b1, 2'b00, 1'b1, 3'd3, 3'd5, 8'h03, 8'h05});
    end
  endtask

  task automatic test_async_reset();
    tests++;
    if (bus.idex_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: got %b want 1", bus.idex_valid);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (obs !== 26'h0) begin
      fails++;
      $display("FAIL async_reset_clear: got %h want %h", obs, 26'h0);
    end
    // WB write presented across an edge while reset is held must be lost
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd7;
    bus.wb_data = 8'hFF;
    step();
    bus.wb_en = 1'b0;
    reset = 1'b1;
    bus.instruction_code = 8'h7F;
    step();
    tests++;
    if (bus.idex_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_first_edge: got %b want 0", bus.idex_valid);
    end
    bus.instruction_code = 8'h02;
    step();
    tests++;
    if (obs !== {1'b1, 2'b01, 1'b1, 3'd7, 3'd7, 8'h07, 8'h07}) begin
      fails++;
      $display("FAIL reinit_r7: got %h want %h", obs,
               {1'b1, 2'b01, 1'b1, 3'd7, 3'd7, 8'h07, 8'h07});
    end
    step();
    tests++;
    if (obs !== {1'b1, 2'b00, 1'b1, 3'd0, 3'd2, 8'h00, 8'h02}) begin
      fails++;
      $display("FAIL reinit_r2: got %h want %h", obs,
               {1'b1, 2'b00, 1'b1, 3'd0, 3'd2, 8'h00, 8'h02});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_jmp();
    test_bypass();
    test_bypass_same_reg();
    test_write_readback();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Second stage of the 4-stage 8-bit pipeline (IF, ID, EX, WB); sits directly downstream of instruction fetch.
- Latches the fetched 8-bit instruction_code into the IF/ID register and decodes it.
- Reads the 8x8 register file, which is written by the WB stage, and drives the ID/EX pipeline register consumed by EX.
- Owns the register file, including write-back and same-cycle WB-to-ID bypass.

Parameters:
- DATA_W, 8, register and datapath width.
- NREG, 8, number of architectural registers; index width is 3.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; reset==0 clears or initialises all state immediately.
- instruction_code  in  8  instruction from fetch for the current PC; valid every cycle out of reset.
- wb_en  in  1  WB write enable.
- wb_addr  in  3  WB destination register.
- wb_data  in  DATA_W  WB result.
- idex_valid  out  1  ID/EX holds a decoded instruction.
- idex_op  out  2  00 MOV, 01 ADD, 10 JMP (no-op past ID), 11 unused.
- idex_reg_write  out  1  instruction writes rd in WB.
- idex_rd  out  3  destination index, instr[5:3].
- idex_rs  out  3  source index, instr[2:0].
- idex_rd_data  out  DATA_W  value of R[rd] read in ID.
- idex_rs_data  out  DATA_W  value of R[rs] read in ID.

Behaviour:
- ISA decode from the IF/ID instruction ir:
  - ir[7]=1: JMP (target already taken by fetch). idex_op=10, reg_write=0, rd, rs and data fields forced to 0.
  - ir[7:6]=00: MOV rd,rs, reg_write=1.
  - ir[7:6]=01: ADD rd,rs (rd = rd + rs), reg_write=1.
- Reset (reset==0, async):
  - ir=0, ifid_valid=0.
  - All idex_* outputs are 0, including idex_valid=0 and idex_op=00.
  - R[i]=i for i=0..7.
- IF/ID register:
  - On each posedge with reset==1: ir<=instruction_code, ifid_valid<=1.
  - No stall and no flush, because fetch resolves jumps in IF.
- ID/EX register:
  - On each posedge: idex_valid<=ifid_valid, plus the decoded fields and register read data.
  - Latency: instruction present at fetch output before edge N appears on idex_* after edge N+1.
- Register file reads:
  - Combinational reads at indices ir[5:3] and ir[2:0].
  - Bypass: if wb_en and wb_addr equals a read index in the same cycle, that read returns wb_data.
  - Both ports bypass independently.
- Register file write: on posedge with wb_en=1, R[wb_addr]<=wb_data. wb_en=0 means no write.
- Width rules: no arithmetic in this block. Register data passes through unmodified at DATA_W bits.
- Reset mid-operation:
  - All pipeline contents are discarded and the register file is reinitialised.
  - A WB write coincident with reset assertion is lost; reset wins.
- rd==rs: both read ports return the same value, with bypass applied identically.
- Hazards: this block exports idex_rd and idex_rs for the EX forwarding unit.
  - EX-to-ID dependence is not resolved here.
  - WB-to-ID dependence is resolved by the bypass.

Test Plan:
- Reset then release; fetch drives 8'h00 (MOV R0,R0). Required response:
  - First edge: idex_valid stays 0.
  - Second edge: idex_valid=1, op=00, rd=0, rs=0, both data fields=0.
- Drive 8'h4B (ADD R1,R3) with no WB. After 2 edges: op=01, reg_write=1, rd=1, rs=3, rd_data=8'h01, rs_data=8'h03.
- Drive 8'h85 (JMP). After 2 edges: idex_valid=1, op=10, reg_write=0, rd=0, rs=0, both data fields=0.
- Bypass check:
  - Setup: ir=8'h1A (MOV R3,R2) while wb_en=1, wb_addr=2, wb_data=8'hA5 in the same cycle.
  - Next edge: idex_rs_data=8'hA5.
  - Afterwards: a read of R2 returns 8'hA5.
- Write and read back: wb_en=1, wb_addr=7, wb_data=8'h3C for one edge, then decode 8'h3F (MOV R7,R7). Both data fields=8'h3C.
- Async reset mid-stream:
  - Stimulus: assert reset between edges while idex_valid=1.
  - Without waiting for an edge: all idex_* go to 0 and R[i]=i again.
  - Check: a subsequent 8'h7F read returns rd_data=8'h07.
